// File: rtl/out_shift_ctrl.sv
// rtl/out_shift_ctrl.sv - control FSM for the PE output shift register
//
// Sequences one tile through the output shift register: accepts a tile
// configuration, resets the datapath, streams PE results with a fill delay
// D = filter_size - num_cols, drains the last D entries and pulses done.
//
// Optional feature macro: OUT_SHIFT_CTRL_ERR_CHECK_EN
//   defined   : num_cols > filter_size skips LOAD, goes to DONE, err_o sticky
//   undefined : num_cols is clamped to filter_size (D = 0), err_o tied 0
//
// Ports:
//   clk_i, rst_n_i                 clock, asynchronous active-low reset
//   cfg_valid_i / cfg_ready_o      tile configuration handshake
//   cfg_filter_size_i              filter size for the tile
//   cfg_num_cols_i                 active columns for the tile
//   cfg_num_rows_i                 output samples in the tile
//   in_valid_i / in_ready_o        upstream PE-result handshake
//   out_valid_o / out_ready_i      downstream shift-register output handshake
//   filter_size_o                  registered filter size
//   number_of_columns_o/_ld_o/_rst_o  column-count load controls
//   out_reg_shift_ld_o/_rst_o      shift-register shift / clear
//   busy_o, done_o, err_o          status
module out_shift_ctrl #(
  parameter int N             = 3,
  parameter int NUM_COL_WIDTH = $clog2(N + 1),
  parameter int ROW_CNT_WIDTH = 16,
  localparam int FS_WIDTH     = (N > 1) ? $clog2(N) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     cfg_valid_i,
  output logic                     cfg_ready_o,
  input  logic [FS_WIDTH-1:0]      cfg_filter_size_i,
  input  logic [NUM_COL_WIDTH-1:0] cfg_num_cols_i,
  input  logic [ROW_CNT_WIDTH-1:0] cfg_num_rows_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [FS_WIDTH-1:0]      filter_size_o,
  output logic [NUM_COL_WIDTH-1:0] number_of_columns_o,
  output logic                     number_of_columns_ld_o,
  output logic                     number_of_columns_rst_o,
  output logic                     out_reg_shift_ld_o,
  output logic                     out_reg_shift_rst_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STREAM, S_DRAIN, S_DONE} state_t;

  localparam logic [NUM_COL_WIDTH-1:0] COL_ONE = 1;
  localparam logic [ROW_CNT_WIDTH-1:0] ROW_ONE = 1;

  state_t                     state;
  logic [FS_WIDTH-1:0]        fs_q;
  logic [NUM_COL_WIDTH-1:0]   nc_q;
  logic [NUM_COL_WIDTH-1:0]   d_q;
  logic [ROW_CNT_WIDTH-1:0]   rows_q;
  logic [ROW_CNT_WIDTH-1:0]   acc_cnt;
  logic [NUM_COL_WIDTH-1:0]   fill_cnt;
  logic [NUM_COL_WIDTH-1:0]   drain_cnt;

  logic                       cfg_fire;
  logic [NUM_COL_WIDTH-1:0]   cfg_fs_ext;
  logic                       cfg_illegal;
  logic [NUM_COL_WIDTH-1:0]   cfg_nc_eff;
  logic [NUM_COL_WIDTH-1:0]   cfg_d;
  logic                       d_zero;
  logic                       in_rdy;
  logic                       out_vld;
  logic                       shift_ld;

  assign cfg_fire    = cfg_valid_i & cfg_ready_o;
  assign cfg_fs_ext  = NUM_COL_WIDTH'(cfg_filter_size_i);
  assign cfg_illegal = cfg_num_cols_i > cfg_fs_ext;

`ifdef OUT_SHIFT_CTRL_ERR_CHECK_EN
  // Illegal configs never reach STREAM, so the raw column count is kept.
  assign cfg_nc_eff = cfg_num_cols_i;
`else
  assign cfg_nc_eff = cfg_illegal ? cfg_fs_ext : cfg_num_cols_i;
`endif

  assign cfg_d  = cfg_fs_ext - cfg_nc_eff;
  assign d_zero = (d_q == '0);

  // Handshake outputs depend on the live upstream/downstream signals.
  always_comb begin
    in_rdy   = 1'b0;
    out_vld  = 1'b0;
    shift_ld = 1'b0;
    case (state)
      S_STREAM: begin
        if (d_zero) begin
          in_rdy  = out_ready_i;
          out_vld = in_valid_i;
        end else begin
          // While filling, beats enter without producing output.
          in_rdy  = (fill_cnt < d_q) | out_ready_i;
          out_vld = (fill_cnt >= d_q);
        end
        shift_ld = in_valid_i & in_rdy;
      end
      S_DRAIN: begin
        out_vld  = (drain_cnt < d_q);
        shift_ld = out_vld & out_ready_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= S_IDLE;
      fs_q      <= '0;
      nc_q      <= '0;
      d_q       <= '0;
      rows_q    <= '0;
      acc_cnt   <= '0;
      fill_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cfg_fire) begin
            fs_q   <= cfg_filter_size_i;
            nc_q   <= cfg_nc_eff;
            rows_q <= cfg_num_rows_i;
            d_q    <= cfg_d;
`ifdef OUT_SHIFT_CTRL_ERR_CHECK_EN
            state  <= cfg_illegal ? S_DONE : S_LOAD;
`else
            state  <= S_LOAD;
`endif
          end
        end
        S_LOAD: begin
          acc_cnt   <= '0;
          fill_cnt  <= '0;
          drain_cnt <= '0;
          state     <= (rows_q == '0) ? S_DONE : S_STREAM;
        end
        S_STREAM: begin
          if (shift_ld) begin
            acc_cnt <= acc_cnt + ROW_ONE;
            if (fill_cnt < d_q) fill_cnt <= fill_cnt + COL_ONE;
            if (acc_cnt + ROW_ONE == rows_q) state <= d_zero ? S_DONE : S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (shift_ld) begin
            drain_cnt <= drain_cnt + COL_ONE;
            if (drain_cnt + COL_ONE == d_q) state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef OUT_SHIFT_CTRL_ERR_CHECK_EN
  logic err_q;

  // Sticky until reset or the next legal configuration transfer.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)      err_q <= 1'b0;
    else if (cfg_fire) err_q <= cfg_illegal;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  // Gated with reset so the handshake is closed while reset is held.
  assign cfg_ready_o             = rst_n_i & (state == S_IDLE);
  assign in_ready_o              = in_rdy;
  assign out_valid_o             = out_vld;
  assign out_reg_shift_ld_o      = shift_ld;
  assign filter_size_o           = fs_q;
  assign number_of_columns_o     = nc_q;
  assign number_of_columns_ld_o  = (state == S_LOAD);
  // Both datapath clears follow reset combinationally.
  assign number_of_columns_rst_o = ~rst_n_i;
  assign out_reg_shift_rst_o     = ~rst_n_i | (state == S_LOAD);
  assign busy_o                  = (state != S_IDLE);
  assign done_o                  = (state == S_DONE);

endmodule
